ps_adc_avg: RTL and testbench
=============================

Name: ps_adc_avg

Overview:
- Upstream stage of the power-supply digipot controller; produces the `psDig` value that the pot stage consumes.
- Drives the MAX10 modular ADC command/response interface for one fixed channel.
- Accumulates a block of 2^LOG2_N conversions, truncates each to 10 bits, and presents the block average on `psDig` with a one-cycle valid strobe.
- Optionally flags when the average leaves a tolerance window around `psRef`.

Parameters:
- LOG2_N, 3, log2 of samples per average (1..6); N = 2^LOG2_N.
- CHANNEL, 5'd1, ADC channel number driven on `adc_cmd_channel`.
- TIMEOUT, 1023, max cycles spent in WAIT before the conversion is declared lost (must be ≥1).
- TOL, 10'd8, window half-width in LSBs (window feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run request from the control FSM
- adc_cmd_valid  out  1  conversion request to ADC
- adc_cmd_channel  out  5  constant CHANNEL
- adc_cmd_ready  in  1  ADC accepted the command
- adc_rsp_valid  in  1  conversion result valid (single-cycle pulse)
- adc_rsp_data  in  12  conversion result
- psRef  in  10  reference value from UFM (used only with PS_WINDOW_EN)
- psDig  out  10  averaged ADC value
- psDig_valid  out  1  one-cycle strobe; `psDig` is updated in the same cycle
- adc_timeout  out  1  sticky lost-conversion flag
- ps_high  out  1  average above window
- ps_low  out  1  average below window

Behaviour:
- Reset values: psDig=0, psDig_valid=0, adc_cmd_valid=0, adc_timeout=0, ps_high=0, ps_low=0, state=IDLE, acc=0, cnt=0, timer=0.
- Reset mid-operation:
  - Takes effect on the next edge; `adc_cmd_valid` falls that cycle.
  - A partial block is discarded.
  - A later `adc_rsp_valid` arriving in IDLE is ignored.
- Accumulator `acc` is 10+LOG2_N bits, so there is no overflow.
- Each sample = adc_rsp_data[11:2] (truncate two LSBs).
- `cnt` is LOG2_N bits.
- State IDLE:
  - acc=0, cnt=0.
  - If enable=1, go to REQ.
- State REQ:
  - adc_cmd_valid=1.
  - When adc_cmd_ready=1, go to WAIT with timer=0.
  - adc_rsp_valid is ignored in REQ.
  - There is no timeout while stalled on adc_cmd_ready.
- State WAIT:
  - adc_cmd_valid=0; timer increments each cycle.
  - On adc_rsp_valid: acc += sample.
    - If cnt==N-1, go to DONE.
    - Otherwise cnt++ and return to REQ.
  - If timer reaches TIMEOUT with no response:
    - Set adc_timeout=1.
    - Discard the block (acc=0, cnt=0) and go to IDLE.
  - If adc_rsp_valid and timer==TIMEOUT occur in the same cycle, the response wins (no timeout).
- State DONE (one cycle):
  - psDig <= acc >> LOG2_N; psDig_valid=1.
  - Window flags are updated from the same new average.
  - acc=0, cnt=0.
  - Next state is REQ if enable=1, else IDLE.
- Latency: psDig_valid is asserted exactly one cycle after the clock edge that accepted the N-th response.
- `enable` is sampled only in IDLE and DONE. Deasserting it mid-block lets the block complete and publish.
- `psDig` holds its last value between strobes.
- `adc_timeout` clears only on reset.
- Minimum per-sample cost is 2 cycles (REQ→WAIT), plus ADC latency.

Optional Feature:
- Macro: PS_WINDOW_EN.
- With PS_WINDOW_EN defined, both flags are computed in DONE at 11-bit width (no wrap) and held until the next DONE:
  - ps_high = ({1'b0,avg} > {1'b0,psRef} + TOL)
  - ps_low = ({1'b0,avg} + TOL < {1'b0,psRef})
- Without the macro, ps_high and ps_low are constant 0 and psRef is unused; no comparator logic is synthesized.

Test Plan:
- Reset, enable=1, ADC model answers 3 cycles after ready with 12'h800 for 8 samples (LOG2_N=3) -> psDig=10'h200, psDig_valid high for exactly 1 cycle, one cycle after the 8th response.
- Responses 12'h000,12'h004,...,12'h01C (sample = 0..7, sum 28) -> psDig=3; with enable held high, adc_cmd_valid rises again the cycle after DONE.
- adc_cmd_ready held low for 50 cycles -> adc_cmd_valid stays high, adc_timeout stays 0; release ready -> normal completion.
- Suppress the response after the 4th sample -> adc_timeout=1 after TIMEOUT cycles in WAIT, state IDLE, psDig unchanged, no psDig_valid; the next block averages from zero.
- Assert reset while in WAIT after 5 samples -> the next cycle shows all outputs at reset values; a late adc_rsp_valid is ignored; the next full block averages correctly.
- With PS_WINDOW_EN, psRef=10'h200, TOL=8: average 0x209 -> ps_high=1; average 0x1F7 -> ps_low=1; average 0x208 -> both 0. Without the macro, both are always 0.

Source files
------------

// File: rtl/ps_adc_avg.sv
// Averages 2^LOG2_N MAX10 ADC conversions into psDig; psDig_valid strobes one cycle after the edge taking the last response.
// Stalls indefinitely in REQ on adc_cmd_ready; window flags are built only when PS_WINDOW_EN is defined.
module ps_adc_avg #(
   parameter int         LOG2_N  = 3,
   parameter logic [4:0] CHANNEL = 5'd1,
   parameter int         TIMEOUT = 1023,
   parameter logic [9:0] TOL     = 10'd8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        adc_cmd_valid,
   output logic [4:0]  adc_cmd_channel,
   input  logic        adc_cmd_ready,
   input  logic        adc_rsp_valid,
   input  logic [11:0] adc_rsp_data,
   input  logic [9:0]  psRef,
   output logic [9:0]  psDig,
   output logic        psDig_valid,
   output logic        adc_timeout,
   output logic        ps_high,
   output logic        ps_low
);
   localparam int AW = 10 + LOG2_N;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t            state;
   logic [AW-1:0]     acc;
   logic [LOG2_N-1:0] cnt;
   logic [TW-1:0]     timer;
   logic [AW-1:0]     sample;
   logic [9:0]        avg;

   assign sample          = {{LOG2_N{1'b0}}, adc_rsp_data[11:2]};
   assign avg             = acc[AW-1:LOG2_N];
   assign adc_cmd_channel = CHANNEL;

`ifdef PS_WINDOW_EN
   // 11-bit compare so psRef + TOL cannot wrap
   logic [10:0] avg_w;
   logic [10:0] ref_w;
   logic        win_high;
   logic        win_low;
   logic        unused_bits;

   assign avg_w       = {1'b0, avg};
   assign ref_w       = {1'b0, psRef};
   assign win_high    = avg_w > (ref_w + {1'b0, TOL});
   assign win_low     = (avg_w + {1'b0, TOL}) < ref_w;
   assign unused_bits = ^adc_rsp_data[1:0];
`else
   logic unused_bits;

   assign ps_high     = 1'b0;
   assign ps_low      = 1'b0;
   assign unused_bits = ^{psRef, adc_rsp_data[1:0]};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         acc           <= '0;
         cnt           <= '0;
         timer         <= '0;
         adc_cmd_valid <= 1'b0;
         psDig         <= '0;
         psDig_valid   <= 1'b0;
         adc_timeout   <= 1'b0;
`ifdef PS_WINDOW_EN
         ps_high       <= 1'b0;
         ps_low        <= 1'b0;
`endif
      end else begin
         psDig_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               acc   <= '0;
               cnt   <= '0;
               timer <= '0;
               if (enable) begin
                  state         <= S_REQ;
                  adc_cmd_valid <= 1'b1;
               end
            end
            S_REQ: begin
               if (adc_cmd_ready) begin
                  adc_cmd_valid <= 1'b0;
                  timer         <= '0;
                  state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               // a response landing on the last timer cycle still counts
               if (adc_rsp_valid) begin
                  acc <= acc + sample;
                  if (&cnt) begin
                     state <= S_DONE;
                  end else begin
                     cnt           <= cnt + 1'b1;
                     state         <= S_REQ;
                     adc_cmd_valid <= 1'b1;
                  end
               end else if (timer == TIMER_MAX) begin
                  adc_timeout <= 1'b1;
                  acc         <= '0;
                  cnt         <= '0;
                  state       <= S_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_DONE: begin
               psDig       <= avg;
               psDig_valid <= 1'b1;
`ifdef PS_WINDOW_EN
               ps_high     <= win_high;
               ps_low      <= win_low;
`endif
               acc         <= '0;
               cnt         <= '0;
               if (enable) begin
                  state         <= S_REQ;
                  adc_cmd_valid <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ps_adc_avg.sv
// Directed bench for ps_adc_avg: ADC responder, protocol-level averaging model and literal block checks.
module tb_ps_adc_avg;
   localparam int         LOG2_N  = 3;
   localparam int         N       = 8;
   localparam int         TIMEOUT = 1023;
   localparam logic [9:0] TOL     = 10'd8;
`ifdef PS_WINDOW_EN
   localparam bit WIN = 1'b1;
`else
   localparam bit WIN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        adc_cmd_ready = 1'b0;
   logic        adc_rsp_valid = 1'b0;
   logic [11:0] adc_rsp_data = '0;
   logic [9:0]  psRef = 10'h200;
   logic        adc_cmd_valid;
   logic [4:0]  adc_cmd_channel;
   logic [9:0]  psDig;
   logic        psDig_valid;
   logic        adc_timeout;
   logic        ps_high;
   logic        ps_low;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ps_adc_avg #(
      .LOG2_N (LOG2_N),
      .CHANNEL(5'd1),
      .TIMEOUT(TIMEOUT),
      .TOL    (TOL)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .adc_cmd_valid  (adc_cmd_valid),
      .adc_cmd_channel(adc_cmd_channel),
      .adc_cmd_ready  (adc_cmd_ready),
      .adc_rsp_valid  (adc_rsp_valid),
      .adc_rsp_data   (adc_rsp_data),
      .psRef          (psRef),
      .psDig          (psDig),
      .psDig_valid    (psDig_valid),
      .adc_timeout    (adc_timeout),
      .ps_high        (ps_high),
      .ps_low         (ps_low)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a command handshake opens a response window; responses inside it are
   // collected, N of them publish their mean one edge later; a silent window of
   // TIMEOUT+1 cycles loses the block and raises the sticky timeout.
   int         m_sum = 0, m_cnt = 0, m_w = 0, m_avg = 0;
   bit         m_waiting = 0, m_pub = 0;
   bit         m_valid = 0, m_to = 0, m_hi = 0, m_lo = 0;
   logic [9:0] m_psdig = '0;
   logic       cmd_q = 1'b0;
   bit         run_chk = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_sum = 0; m_cnt = 0; m_w = 0; m_waiting = 0; m_pub = 0;
         m_valid = 0; m_to = 0; m_hi = 0; m_lo = 0; m_psdig = '0;
      end else begin
         m_valid = m_pub;
         if (m_pub) begin
            m_psdig = 10'(m_avg);
            m_hi = WIN && (m_avg > int'(psRef) + int'(TOL));
            m_lo = WIN && (m_avg + int'(TOL) < int'(psRef));
         end
         m_pub = 0;
         if (m_waiting) begin
            if (adc_rsp_valid) begin
               m_waiting = 0;
               m_sum += int'(adc_rsp_data) / 4;
               m_cnt++;
               if (m_cnt == N) begin
                  m_avg = m_sum / N;
                  m_pub = 1;
                  m_sum = 0;
                  m_cnt = 0;
               end
            end else if (m_w == TIMEOUT) begin
               m_to = 1; m_waiting = 0; m_sum = 0; m_cnt = 0;
            end else begin
               m_w++;
            end
         end else if (cmd_q && adc_cmd_ready) begin
            m_waiting = 1;
            m_w = 0;
         end
      end
   end

   always @(negedge clk) begin
      cmd_q = adc_cmd_valid;
      if (run_chk) begin
         chk("m_psDig_valid", psDig_valid, m_valid);
         chk("m_psDig", psDig, m_psdig);
         chk("m_adc_timeout", adc_timeout, m_to);
         chk("m_ps_high", ps_high, m_hi);
         chk("m_ps_low", ps_low, m_lo);
         chk("m_channel", adc_cmd_channel, 5'd1);
      end
   end

   task automatic wait_cmd();
      int t = 0;
      while (adc_cmd_valid !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("cmd_valid_wait", adc_cmd_valid, 1'b1);
   endtask

   // Accept one command; optionally answer 3 cycles after the handshake edge.
   task automatic do_sample(input logic [11:0] d, input bit respond);
      wait_cmd();
      adc_cmd_ready = 1'b1;
      @(negedge clk);
      adc_cmd_ready = 1'b0;
      if (respond) begin
         @(negedge clk);
         @(negedge clk);
         adc_rsp_valid = 1'b1;
         adc_rsp_data  = d;
         @(negedge clk);
         adc_rsp_valid = 1'b0;
      end
   endtask

   task automatic run_block(input string name, input logic [11:0] base, input logic [11:0] step,
                            input logic [9:0] exp, input int drop_at);
      logic [11:0] d;
      for (int i = 0; i < N; i++) begin
         if (i == drop_at) enable = 1'b0;
         d = base + 12'(i) * step;
         do_sample(d, 1'b1);
      end
      chk({name, "_no_early_valid"}, psDig_valid, 1'b0);
      @(negedge clk);
      chk({name, "_valid"}, psDig_valid, 1'b1);
      chk({name, "_psDig"}, psDig, exp);
      chk({name, "_cmd_after_done"}, adc_cmd_valid, enable);
      @(negedge clk);
      chk({name, "_valid_one_cycle"}, psDig_valid, 1'b0);
      chk({name, "_psDig_held"}, psDig, exp);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      run_chk = 1;
      chk("rst_psDig", psDig, 10'h0);
      chk("rst_valid", psDig_valid, 1'b0);
      chk("rst_cmd", adc_cmd_valid, 1'b0);
      chk("rst_timeout", adc_timeout, 1'b0);
      reset  = 1'b0;
      enable = 1'b1;

      run_block("mid", 12'h800, 12'h000, 10'h200, -1);
      run_block("ramp", 12'h000, 12'h004, 10'h003, -1);

      wait_cmd();
      for (int i = 0; i < 50; i++) begin
         chk("stall_cmd", adc_cmd_valid, 1'b1);
         chk("stall_timeout", adc_timeout, 1'b0);
         @(negedge clk);
      end
      run_block("stall", 12'h400, 12'h000, 10'h100, -1);

      for (int i = 0; i < 4; i++) do_sample(12'hFFC, 1'b1);
      do_sample(12'h000, 1'b0);
      repeat (TIMEOUT) @(negedge clk);
      chk("to_not_yet", adc_timeout, 1'b0);
      @(negedge clk);
      chk("to_set", adc_timeout, 1'b1);
      chk("to_idle_cmd", adc_cmd_valid, 1'b0);
      chk("to_psDig_kept", psDig, 10'h100);
      run_block("after_to", 12'h800, 12'h000, 10'h200, -1);
      chk("to_sticky", adc_timeout, 1'b1);

      for (int i = 0; i < 5; i++) do_sample(12'hFFC, 1'b1);
      do_sample(12'h000, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mrst_psDig", psDig, 10'h0);
      chk("mrst_valid", psDig_valid, 1'b0);
      chk("mrst_cmd", adc_cmd_valid, 1'b0);
      chk("mrst_timeout", adc_timeout, 1'b0);
      adc_rsp_valid = 1'b1;
      adc_rsp_data  = 12'hFFF;
      @(negedge clk);
      adc_rsp_valid = 1'b0;
      chk("mrst_req_again", adc_cmd_valid, 1'b1);
      run_block("after_rst", 12'h100, 12'h040, 10'h078, -1);

      run_block("win_hi", 12'h824, 12'h000, 10'h209, -1);
      chk("win_hi_high", ps_high, WIN);
      chk("win_hi_low", ps_low, 1'b0);
      run_block("win_lo", 12'h7DC, 12'h000, 10'h1F7, -1);
      chk("win_lo_high", ps_high, 1'b0);
      chk("win_lo_low", ps_low, WIN);
      run_block("win_in", 12'h820, 12'h000, 10'h208, -1);
      chk("win_in_high", ps_high, 1'b0);
      chk("win_in_low", ps_low, 1'b0);

      run_block("drop_en", 12'h600, 12'h000, 10'h180, 3);
      repeat (5) @(negedge clk);
      chk("drop_en_idle", adc_cmd_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
